// File: rtl/rv32e_mem_arbiter_if.sv
// rv32e_mem_arbiter_if: groups the fetch port, data port, memory bus and
// stall signals that surround the RV32E memory arbiter.
interface rv32e_mem_arbiter_if;
  // Instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  // Data (load/store) port
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        bus_err;
  // Single-port memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  // Pipeline stalls
  logic        stall_if;
  logic        stall_mem;

  // Arbiter view: serves the CPU ports and masters the memory bus
  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, d_wstrb,
    input  mem_rdata, mem_ready,
    output if_rdata, if_valid, d_rdata, d_done, bus_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output stall_if, stall_mem
  );

  // Environment view: CPU pipeline requesting, memory responding
  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, d_wstrb,
    output mem_rdata, mem_ready,
    input  if_rdata, if_valid, d_rdata, d_done, bus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/rv32e_mem_arbiter.sv
// rv32e_mem_arbiter: shares one single-port memory between the RV32E fetch
// port and the load/store port. Data wins ties, but after STARVE_LIMIT data
// grants in a row with a fetch waiting, the fetch is forced through. Each
// access is bounded by TIMEOUT cycles and reports bus_err when it expires.
module rv32e_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic               clk,
  input  logic               rst,
  rv32e_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e      state_q,     state_d;
  logic [3:0]  streak_q,    streak_d;
  logic [7:0]  timer_q,     timer_d;
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic        if_valid_q,  if_valid_d;
  logic [31:0] d_rdata_q,   d_rdata_d;
  logic        d_done_q,    d_done_d;
  logic        bus_err_q,   bus_err_d;

  logic        d_any_s;
  logic        starve_s;
  logic        data_grant_s;

  // A waiting fetch blocks data only once the data streak is saturated
  assign d_any_s      = bus.d_read | bus.d_write;
  assign starve_s     = bus.if_req & (streak_q == STREAK_MAX);
  assign data_grant_s = d_any_s & ~starve_s;

  // Next-state, bus launch, capture and completion-pulse logic
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = 8'd0;
        if (data_grant_s) begin
          state_d     = ST_BUSY_D;
          mem_req_d   = 1'b1;
          // Read and write together is served as a write
          mem_we_d    = bus.d_write;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_wstrb_d = bus.d_write ? bus.d_wstrb : 4'b0000;
          if (bus.if_req) begin
            if (streak_q < STREAK_MAX) begin
              streak_d = streak_q + 4'd1;
            end else begin
              streak_d = STREAK_MAX;
            end
          end else begin
            streak_d = 4'd0;
          end
        end else if (bus.if_req) begin
          state_d     = ST_BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = 32'd0;
          mem_wstrb_d = 4'b0000;
          streak_d    = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        timer_d = timer_q + 8'd1;
        if (bus.mem_ready) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (state_q == ST_BUSY_I) begin
            if_rdata_d = bus.mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            d_done_d = 1'b1;
            // Stores leave the last load value in place
            if (!mem_we_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d    = ST_RESP;
          mem_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          if_valid_d = (state_q == ST_BUSY_I);
          d_done_d   = (state_q == ST_BUSY_D);
        end else begin
          state_d = state_q;
        end
      end
      ST_RESP: begin
        // Dead cycle so a request still held high is not served twice
        timer_d = 8'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        timer_d   = 8'd0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      streak_q    <= 4'd0;
      timer_q     <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'b0000;
      if_rdata_q  <= 32'd0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.bus_err   = bus_err_q;

  // Stalls release in the same cycle as the completion pulse
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = d_any_s & ~d_done_q;

endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// tb_rv32e_mem_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level reference of the arbitration rules.
module tb_rv32e_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 64;

  logic clk;
  logic rst;
  rv32e_mem_arbiter_if bus();

  rv32e_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws);
    bus.d_read  = rd;
    bus.d_write = wr;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_wstrb = ws;
  endtask

  task automatic clr_data();
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  // Acts as the memory for one access: expects the given grant after
  // wait_cycles edges, answers after 'delay' request cycles (or never when
  // tmo), then checks the completion cycle. Returns inside that cycle.
  task automatic serve(input string tag, input bit is_data, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int wait_cycles,
                       input int delay, input bit tmo);
    int w;
    int k;
    bit done;
    bit stable;
    logic [31:0] rd;
    logic [3:0] exp_strb;
    rd = $urandom;
    exp_strb = (is_data && we) ? wstrb : 4'b0000;
    w = 0;
    while (bus.mem_req !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk32({tag, " grant_latency"}, 32'(w), 32'(wait_cycles));
    chk1({tag, " mem_we"}, bus.mem_we, we);
    chk32({tag, " mem_addr"}, bus.mem_addr, addr);
    chk32({tag, " mem_wstrb"}, {28'd0, bus.mem_wstrb}, {28'd0, exp_strb});
    if (we) chk32({tag, " mem_wdata"}, bus.mem_wdata, wdata);
    if (is_data) chk1({tag, " stall_mem_busy"}, bus.stall_mem, 1'b1);
    else         chk1({tag, " stall_if_busy"}, bus.stall_if, 1'b1);
    k = 0;
    done = 1'b0;
    stable = 1'b1;
    while (!done && k < 300) begin
      k++;
      if (!tmo && k == delay) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
      tick();
      bus.mem_ready = 1'b0;
      if (bus.mem_req !== 1'b1) done = 1'b1;
      else if (bus.mem_addr !== addr || bus.mem_we !== we || bus.mem_wstrb !== exp_strb)
        stable = 1'b0;
    end
    chk1({tag, " bus_stable"}, stable, 1'b1);
    chk32({tag, " req_cycles"}, 32'(k), tmo ? 32'(TIMEOUT) : 32'(delay));
    chk1({tag, " if_valid"}, bus.if_valid, !is_data);
    chk1({tag, " d_done"}, bus.d_done, is_data);
    chk1({tag, " bus_err"}, bus.bus_err, tmo);
    if (!tmo) begin
      if (!is_data) exp_if_rdata = rd;
      else if (!we) exp_d_rdata = rd;
    end
    chk32({tag, " if_rdata"}, bus.if_rdata, exp_if_rdata);
    chk32({tag, " d_rdata"}, bus.d_rdata, exp_d_rdata);
    if (is_data) chk1({tag, " stall_mem_done"}, bus.stall_mem, 1'b0);
    else         chk1({tag, " stall_if_done"}, bus.stall_if, 1'b0);
  endtask

  bit          fp, dp, dwe, first, gd, tmo;
  logic [31:0] fa, da, dwd;
  logic [3:0]  dst;
  int          streak_m, dsel;

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = 32'd0;
    set_data(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    exp_if_rdata = 32'd0;
    exp_d_rdata = 32'd0;

    // Reset state
    tick();
    tick();
    chk1("rst mem_req", bus.mem_req, 1'b0);
    chk1("rst mem_we", bus.mem_we, 1'b0);
    chk1("rst if_valid", bus.if_valid, 1'b0);
    chk1("rst d_done", bus.d_done, 1'b0);
    chk1("rst bus_err", bus.bus_err, 1'b0);
    chk32("rst mem_addr", bus.mem_addr, 32'd0);
    chk32("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk32("rst mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    chk32("rst if_rdata", bus.if_rdata, 32'd0);
    chk32("rst d_rdata", bus.d_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // Fetch only, memory answers on the second request cycle
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0000_0100;
    serve("fetch", 1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'd0, 1, 2, 1'b0);
    bus.if_req = 1'b0;
    tick();
    chk1("fetch pulse_once", bus.if_valid, 1'b0);

    // Collision: data first, fetch in the first idle after d_done
    set_data(1'b1, 1'b0, 32'h0000_2000, 32'd0, 4'b0000);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0000_0104;
    serve("coll data", 1'b1, 1'b0, 32'h0000_2000, 32'd0, 4'd0, 1, 1, 1'b0);
    clr_data();
    serve("coll fetch", 1'b0, 1'b0, 32'h0000_0104, 32'd0, 4'd0, 2, 3, 1'b0);
    bus.if_req = 1'b0;
    tick();

    // Store with partial strobes
    set_data(1'b0, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011);
    serve("store", 1'b1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 1, 1, 1'b0);
    clr_data();
    tick();
    chk1("store pulse_once", bus.d_done, 1'b0);
    chk1("idle stall_mem", bus.stall_mem, 1'b0);

    // Starvation: four data grants, then the waiting fetch
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0000_0200;
    set_data(1'b1, 1'b0, 32'h0000_3000, 32'd0, 4'b0000);
    for (int j = 0; j < 4; j++) begin
      serve("starve data", 1'b1, 1'b0, 32'h0000_3000 + 32'(4 * j), 32'd0, 4'd0,
            (j == 0) ? 1 : 2, 2, 1'b0);
      set_data(1'b1, 1'b0, 32'h0000_3000 + 32'(4 * (j + 1)), 32'd0, 4'b0000);
    end
    serve("starve fetch", 1'b0, 1'b0, 32'h0000_0200, 32'd0, 4'd0, 2, 1, 1'b0);
    bus.if_req = 1'b0;
    serve("starve data_after", 1'b1, 1'b0, 32'h0000_3010, 32'd0, 4'd0, 2, 1, 1'b0);
    clr_data();
    tick();

    // Timeout, then a normal access
    set_data(1'b1, 1'b0, 32'h0000_4000, 32'd0, 4'b0000);
    serve("timeout", 1'b1, 1'b0, 32'h0000_4000, 32'd0, 4'd0, 1, 0, 1'b1);
    clr_data();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0000_0108;
    serve("post_tmo fetch", 1'b0, 1'b0, 32'h0000_0108, 32'd0, 4'd0, 2, 1, 1'b0);
    bus.if_req = 1'b0;
    tick();
    chk1("post_tmo bus_err_clear", bus.bus_err, 1'b0);

    // Reset in the middle of a store
    set_data(1'b0, 1'b1, 32'h0000_5000, 32'hCAFE_F00D, 4'b1111);
    tick();
    chk1("rstmid mem_req_up", bus.mem_req, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    exp_if_rdata = 32'd0;
    exp_d_rdata = 32'd0;
    chk1("rstmid mem_req", bus.mem_req, 1'b0);
    chk1("rstmid d_done", bus.d_done, 1'b0);
    chk32("rstmid mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    rst = 1'b0;
    clr_data();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk1("rstmid late d_done", bus.d_done, 1'b0);
      chk1("rstmid late if_valid", bus.if_valid, 1'b0);
      chk1("rstmid late mem_req", bus.mem_req, 1'b0);
      tick();
    end
    chk32("rstmid d_rdata", bus.d_rdata, exp_d_rdata);

    // Randomized traffic against the reference arbitration model
    streak_m = 0;
    fp = 1'b0;
    dp = 1'b0;
    dwe = 1'b0;
    first = 1'b1;
    fa = 32'd0;
    da = 32'd0;
    dwd = 32'd0;
    dst = 4'd0;
    for (int i = 0; i < 40; i++) begin
      if (!fp && $urandom_range(0, 1) == 1) begin
        fp = 1'b1;
        fa = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
        bus.if_req = 1'b1;
        bus.if_addr = fa;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1'b1;
        dsel = $urandom_range(0, 2);
        dwe = (dsel != 0);
        da = 32'h0002_0000 | ($urandom & 32'h0000_FFFC);
        dwd = $urandom;
        dst = 4'($urandom_range(1, 15));
        set_data(dsel != 1, dsel != 0, da, dwd, dst);
      end
      if (!fp && !dp) begin
        fp = 1'b1;
        fa = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
        bus.if_req = 1'b1;
        bus.if_addr = fa;
      end
      gd = dp && !(fp && streak_m == STARVE_LIMIT);
      tmo = ($urandom_range(0, 11) == 0);
      if (gd) begin
        serve("rnd data", 1'b1, dwe, da, dwd, dst, first ? 1 : 2,
              $urandom_range(1, 4), tmo);
        streak_m = fp ? ((streak_m < STARVE_LIMIT) ? streak_m + 1 : STARVE_LIMIT) : 0;
        dp = 1'b0;
        clr_data();
      end else begin
        serve("rnd fetch", 1'b0, 1'b0, fa, 32'd0, 4'd0, first ? 1 : 2,
              $urandom_range(1, 4), tmo);
        streak_m = 0;
        fp = 1'b0;
        bus.if_req = 1'b0;
      end
      first = 1'b0;
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32e_mem_arbiter.md
Name: rv32e_mem_arbiter

Overview:
- Shares one single-port memory between the RV32E instruction-fetch port and the data (load/store) port.
- The data port is driven by the decoded MemRead/MemWrite control bits.
- Data accesses have priority. A streak counter stops instruction fetch from starving.
- Generates pipeline stall signals, one-cycle completion pulses, and a bus-error flag on memory timeout.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while if_req is pending before fetch is forced (1..15)
TIMEOUT, 64, max cycles a grant waits for mem_ready before aborting with error (2..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held until if_valid
if_addr  in  32  fetch byte address
if_rdata  out  32  fetched word, valid with if_valid
if_valid  out  1  one-cycle fetch completion pulse
d_read  in  1  load request (MemRead); held until d_done
d_write  in  1  store request (MemWrite); held until d_done
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_wstrb  in  4  store byte enables
d_rdata  out  32  load data, valid with d_done
d_done  out  1  one-cycle data completion pulse
bus_err  out  1  pulses with if_valid/d_done when the access timed out
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte enables (4'b0000 on reads)
mem_rdata  in  32  memory read data, valid with mem_ready
mem_ready  in  1  memory accepts/completes current access
stall_if  out  1  fetch stage must hold
stall_mem  out  1  memory stage must hold

Behaviour:
- Reset is synchronous:
  - state=IDLE, streak=0, timer=0.
  - mem_req, mem_we, if_valid, d_done, bus_err = 0.
  - mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata = 0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE arbitration, sampled at the clock edge:
  - Grant data if (d_read|d_write) and not (if_req and streak==STARVE_LIMIT).
  - Otherwise grant fetch if if_req.
  - Otherwise stay in IDLE.
- On grant, register the address, wdata and wstrb into the mem_* outputs. mem_req=1 from the next cycle.
- Data grant: mem_we=d_write. d_read and d_write both high is treated as a write.
- Fetch grant: mem_we=0, mem_wstrb=0.
- Streak counter:
  - Data grant while if_req=1: streak++, saturating at STARVE_LIMIT.
  - Any fetch grant, or a data grant with if_req=0: streak=0.
- BUSY_x: mem_* outputs are held stable and timer increments each cycle.
  - mem_ready=1 sampled: capture mem_rdata into if_rdata or d_rdata (store: d_rdata unchanged); mem_req=0; go to RESP.
  - timer reaches TIMEOUT-1 without mem_ready: mem_req=0, set the error flag, go to RESP. rdata is unchanged.
- RESP (exactly one cycle):
  - Pulse if_valid or d_done for the granted port; bus_err=1 only if timed out.
  - No grant is made in this cycle, so a request still held high is not re-served.
  - timer=0; next state is IDLE.
- mem_ready sampled in IDLE or RESP is ignored.
- Latency:
  - Request seen in IDLE at edge N → mem_req high in cycle N+1.
  - mem_ready sampled at edge M → completion pulse in cycle M+1.
  - Minimum 3 cycles from request to the next grant opportunity.
- Stall outputs are combinational:
  - stall_if = if_req & ~if_valid.
  - stall_mem = (d_read|d_write) & ~d_done.
- Reset mid-access: the bus is released (mem_req=0) after the reset edge. No completion pulse is generated and any late mem_ready is ignored.
- Request inputs dropped before completion are a protocol violation. The access still completes; the completion pulse is generated regardless.

Test Plan:
- Fetch only: if_req=1, addr=0x100, memory ready 2 cycles after mem_req, rdata=0x00500093 → mem_req for 2 cycles; if_valid one pulse with if_rdata=0x00500093; stall_if low in that same cycle.
- Collision: d_read=1 (addr=0x2000) and if_req=1 both asserted in IDLE → data granted first, mem_we=0; fetch granted in the first IDLE after d_done.
- Store: d_write=1, addr=0x2004, wdata=0xDEADBEEF, wstrb=4'b0011 → mem_we=1, mem_wstrb=4'b0011, mem_wdata=0xDEADBEEF; d_done pulses once; d_rdata unchanged.
- Starvation: if_req held high, data requests back-to-back, STARVE_LIMIT=4 → exactly 4 data grants, then 1 fetch grant, and the streak counter resets.
- Timeout: mem_ready held low, TIMEOUT=64 → mem_req drops after 64 cycles; d_done and bus_err pulse together; the next access proceeds normally.
- Reset mid-access: rst during BUSY_D → next cycle IDLE with mem_req=0; no d_done; a mem_ready pulse afterward is ignored.
